// File: rtl/dma_req_arb_pkg.sv
// Shared types and default constants for the DMA request arbiter.
// The optional ack timeout is enabled with DMA_REQ_ARB_TIMEOUT_EN.
package dma_req_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_SINGLE = 1'b0,
    REQ_BURST  = 1'b1
  } req_type_e;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_ACK_TIMEOUT = 4096;

endpackage

// File: rtl/dma_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first active index at or above ptr_i,
// wrapping around; valid_o is low when nothing is active.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    active_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] idx_o,
  output logic            valid_o
);

  int j;

  // Walk from the farthest candidate back to ptr_i so the last hit is the nearest.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (active_i[j]) begin
        idx_o   = j[ID_W-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_req_arbiter.sv
// Round-robin sharing of one HPS DMA peripheral request channel between NUM_REQ
// requesters. Optional ack timeout abort: define DMA_REQ_ARB_TIMEOUT_EN.
module dma_req_arbiter
  import dma_req_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic [NUM_REQ-1:0] req_single,
  input  logic [NUM_REQ-1:0] req_burst,
  output logic [NUM_REQ-1:0] req_ack,
  output logic               dma_req,
  output logic               dma_single,
  input  logic               dma_ack,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr,
  output logic [1:0]         dbg_state
);

  arb_state_e         state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    grant_id_q;
  logic               dma_req_q;
  logic               dma_single_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] req_ack_q;

  logic [NUM_REQ-1:0] active;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_valid;
  req_type_e          pick_type;
  logic [ID_W-1:0]    next_ptr;
  logic               expired;

  assign active    = req_single | req_burst;
  assign pick_type = req_burst[pick_idx] ? REQ_BURST : REQ_SINGLE;
  assign next_ptr  = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .active_i (active),
    .ptr_i    (rr_ptr_q),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

`ifdef DMA_REQ_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_err_q;

  assign expired = (state_q == REQ) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign cnt_d   = (state_q == REQ && !dma_ack && !expired) ? cnt_q + CNT_W'(1) : '0;

  // A timeout raised in the same cycle as err_clr stays set.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (expired && !dma_ack) timeout_err_q <= 1'b1;
      else if (err_clr)        timeout_err_q <= 1'b0;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  localparam int unsigned UNUSED_ACK_TIMEOUT = ACK_TIMEOUT;
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign expired        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // Handshake: a committed request holds until dma_ack (or timeout); the channel
  // then rests in RELEASE until dma_ack falls before another grant can be made.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      dma_req_q    <= 1'b0;
      dma_single_q <= 1'b0;
      busy_q       <= 1'b0;
      req_ack_q    <= '0;
    end else begin
      req_ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_id_q   <= pick_idx;
            dma_req_q    <= (pick_type == REQ_BURST);
            dma_single_q <= (pick_type == REQ_SINGLE);
            busy_q       <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (dma_ack) begin
            dma_req_q             <= 1'b0;
            dma_single_q          <= 1'b0;
            req_ack_q[grant_id_q] <= 1'b1;
            rr_ptr_q              <= next_ptr;
            state_q               <= RELEASE;
          end else if (expired) begin
            dma_req_q    <= 1'b0;
            dma_single_q <= 1'b0;
            rr_ptr_q     <= next_ptr;
            state_q      <= RELEASE;
          end
        end
        RELEASE: begin
          if (!dma_ack) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          dma_req_q    <= 1'b0;
          dma_single_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign req_ack    = req_ack_q;
  assign dma_req    = dma_req_q;
  assign dma_single = dma_single_q;
  assign grant_id   = grant_id_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule
